// File: rtl/sobel_pkg.sv
// sobel_pkg: shared gradient width, direction codes and 3x3 window indices.
// Optional build macro SOBEL_DIR_EN (used by sobel_mask_pipe) enables the direction output.
package sobel_pkg;

    // Signed gradient width: worst case |g| = 4*(2^PIXEL_W-1) plus sign, and |gx|+|gy| fits unsigned.
    function automatic int grad_width(input int pixel_w);
        return pixel_w + 3;
    endfunction

    typedef enum logic [1:0] {
        DIR_VERT    = 2'd0,
        DIR_HORIZ   = 2'd1,
        DIR_DIAG45  = 2'd2,
        DIR_DIAG135 = 2'd3
    } sobel_dir_e;

    // Row-major window positions (top-left .. bottom-right).
    localparam int P_TL = 0;
    localparam int P_T  = 1;
    localparam int P_TR = 2;
    localparam int P_L  = 3;
    localparam int P_C  = 4;
    localparam int P_R  = 5;
    localparam int P_BL = 6;
    localparam int P_B  = 7;
    localparam int P_BR = 8;

endpackage

// File: rtl/sobel_abs_sat.sv
// sobel_abs_sat: combinational L1 gradient magnitude with saturation to PIXEL_W.
// Ports:
//   i_gx, i_gy : signed gradients (G = PIXEL_W+3 bits)
//   o_sum      : |i_gx| + |i_gy|, unsigned G bits
//   i_sum      : a (possibly registered) sum to be saturated
//   o_mag      : all-ones when i_sum >= 2^PIXEL_W, else i_sum[PIXEL_W-1:0]
// The sum and saturation halves are separate so a pipeline register can sit between them.
module sobel_abs_sat
    import sobel_pkg::*;
#(
    parameter int PIXEL_W = 8,
    localparam int G = grad_width(PIXEL_W)
) (
    input  logic signed [G-1:0]       i_gx,
    input  logic signed [G-1:0]       i_gy,
    output logic        [G-1:0]       o_sum,
    input  logic        [G-1:0]       i_sum,
    output logic        [PIXEL_W-1:0] o_mag
);

    logic [G-1:0] w_ax;
    logic [G-1:0] w_ay;

    always_comb begin
        w_ax  = i_gx[G-1] ? $unsigned(-i_gx) : $unsigned(i_gx);
        w_ay  = i_gy[G-1] ? $unsigned(-i_gy) : $unsigned(i_gy);
        o_sum = w_ax + w_ay;
        o_mag = (|i_sum[G-1:PIXEL_W]) ? '1 : i_sum[PIXEL_W-1:0];
    end

endmodule

// File: rtl/sobel_mask_pipe.sv
// sobel_mask_pipe: 3-stage valid/ready Sobel kernel producing saturated L1 magnitude or a binary edge.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   win_i, valid_i, ready_o : input 3x3 window (pixel k at [k*PIXEL_W +: PIXEL_W]) handshake
//   thresh_en_i, thresh_i   : per-window threshold mode and value, sampled with win_i
//   pix_o, valid_o, ready_i : result handshake
//   dir_o                   : quantised gradient direction (only with SOBEL_DIR_EN defined)
// Optional build macro: SOBEL_DIR_EN.
module sobel_mask_pipe
    import sobel_pkg::*;
#(
    parameter int PIXEL_W         = 8,
    parameter bit THRESH_MODE_DEF = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [9*PIXEL_W-1:0]   win_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   thresh_en_i,
    input  logic [PIXEL_W-1:0]     thresh_i,
    output logic [PIXEL_W-1:0]     pix_o,
    output logic                   valid_o,
`ifdef SOBEL_DIR_EN
    output logic [1:0]             dir_o,
`endif
    input  logic                   ready_i
);

    localparam int G = grad_width(PIXEL_W);

    logic signed [G-1:0]       w_p [9];
    logic signed [G-1:0]       w_gx;
    logic signed [G-1:0]       w_gy;
    logic signed [G-1:0]       r_gx;
    logic signed [G-1:0]       r_gy;
    logic [G-1:0]              w_sum;
    logic [G-1:0]              r_sum;
    logic [PIXEL_W-1:0]        w_mag;
    logic [PIXEL_W-1:0]        w_pix;
    logic [PIXEL_W-1:0]        r_s1_thr;
    logic [PIXEL_W-1:0]        r_s2_thr;
    logic [PIXEL_W-1:0]        r_pix;
    logic                      r_s1_valid;
    logic                      r_s2_valid;
    logic                      r_s3_valid;
    logic                      r_s1_ten;
    logic                      r_s2_ten;
    logic                      w_s3_ready;
    logic                      w_s2_ready;
    logic                      w_s2_drain;
    logic                      w_s1_drain;
    logic                      w_accept;

    // Pixels are zero-extended so every difference is exact in G signed bits.
    always_comb begin
        for (int k = 0; k < 9; k++) w_p[k] = $signed({3'b000, win_i[k*PIXEL_W +: PIXEL_W]});
        w_gx = (w_p[P_TR] - w_p[P_TL]) + ((w_p[P_R] - w_p[P_L]) <<< 1) + (w_p[P_BR] - w_p[P_BL]);
        w_gy = (w_p[P_TL] - w_p[P_BL]) + ((w_p[P_T] - w_p[P_B]) <<< 1) + (w_p[P_TR] - w_p[P_BR]);
    end

    // A stage may load when empty or when its content moves on in the same cycle,
    // so bubbles collapse and a full pipe streams at one window per cycle.
    always_comb begin
        w_s3_ready = ~r_s3_valid | ready_i;
        w_s2_drain = r_s2_valid & w_s3_ready;
        w_s2_ready = ~r_s2_valid | w_s2_drain;
        w_s1_drain = r_s1_valid & w_s2_ready;
        ready_o    = ~reset_i & (~r_s1_valid | w_s1_drain);
        w_accept   = valid_i & ready_o;
        w_pix      = r_s2_ten ? {PIXEL_W{w_mag >= r_s2_thr}} : w_mag;
    end

    sobel_abs_sat #(
        .PIXEL_W (PIXEL_W)
    ) u_abs_sat (
        .i_gx  (r_gx),
        .i_gy  (r_gy),
        .o_sum (w_sum),
        .i_sum (r_sum),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_gx       <= '0;
            r_gy       <= '0;
            r_s1_ten   <= THRESH_MODE_DEF;
            r_s1_thr   <= '0;
            r_sum      <= '0;
            r_s2_ten   <= THRESH_MODE_DEF;
            r_s2_thr   <= '0;
            r_pix      <= '0;
        end else begin
            if (ready_o) r_s1_valid <= valid_i;
            if (w_accept) begin
                r_gx     <= w_gx;
                r_gy     <= w_gy;
                r_s1_ten <= thresh_en_i;
                r_s1_thr <= thresh_i;
            end
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s1_drain) begin
                r_sum    <= w_sum;
                r_s2_ten <= r_s1_ten;
                r_s2_thr <= r_s1_thr;
            end
            if (w_s3_ready) r_s3_valid <= r_s2_valid;
            if (w_s2_drain) r_pix <= w_pix;
        end
    end

    assign valid_o = r_s3_valid;
    assign pix_o   = r_pix;

`ifdef SOBEL_DIR_EN
    logic [G-1:0] w_ax;
    logic [G-1:0] w_ay;
    sobel_dir_e   w_dir;
    sobel_dir_e   r_s2_dir;
    sobel_dir_e   r_dir;

    // Doubling is done by appending a zero so the comparison never overflows.
    always_comb begin
        w_ax  = r_gx[G-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_ay  = r_gy[G-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_dir = ({1'b0, w_ax} >= {w_ay, 1'b0}) ? DIR_VERT :
                ({1'b0, w_ay} >= {w_ax, 1'b0}) ? DIR_HORIZ :
                (r_gx[G-1] == r_gy[G-1])       ? DIR_DIAG45 : DIR_DIAG135;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s2_dir <= DIR_VERT;
            r_dir    <= DIR_VERT;
        end else begin
            if (w_s1_drain) r_s2_dir <= w_dir;
            if (w_s2_drain) r_dir <= r_s2_dir;
        end
    end

    assign dir_o = r_dir;
`endif

endmodule

// File: tb/tb_sobel_mask_pipe.sv
// tb_sobel_mask_pipe: scoreboard bench for sobel_mask_pipe (8-bit instance plus a 10-bit saturation instance).
module tb_sobel_mask_pipe;

    typedef struct {
        int pix;
        int dir;
        int cyc;
        bit timed;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [71:0] win_i;
    logic        valid_i;
    logic        ready_o;
    logic        thresh_en_i;
    logic [7:0]  thresh_i;
    logic [7:0]  pix_o;
    logic        valid_o;
    logic        ready_i;
    logic [89:0] win10;
    logic        valid10;
    logic        ready10;
    logic [9:0]  pix10;
    logic        valid10_o;
`ifdef SOBEL_DIR_EN
    logic [1:0]  dir_o;
    logic [1:0]  dir10;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   occ = 0;
    exp_t q[$];
    exp_t q10[$];
    exp_t m_e;
    exp_t m_e10;
    bit   m_rdy;
    bit   m_stalled = 0;
    logic [7:0] m_spix;
    logic [1:0] m_sdir;
    bit   pat[4] = '{1, 0, 0, 1};
    logic [71:0] s_w;
    logic        s_te;
    logic [7:0]  s_th;
    int          s_ep;
    int          s_ed;

    always #5 clk = ~clk;

    sobel_mask_pipe #(.PIXEL_W(8), .THRESH_MODE_DEF(1'b0)) u_dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .win_i       (win_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .thresh_en_i (thresh_en_i),
        .thresh_i    (thresh_i),
        .pix_o       (pix_o),
        .valid_o     (valid_o),
`ifdef SOBEL_DIR_EN
        .dir_o       (dir_o),
`endif
        .ready_i     (ready_i)
    );

    sobel_mask_pipe #(.PIXEL_W(10), .THRESH_MODE_DEF(1'b0)) u_dut10 (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .win_i       (win10),
        .valid_i     (valid10),
        .ready_o     (ready10),
        .thresh_en_i (1'b0),
        .thresh_i    (10'd0),
        .pix_o       (pix10),
        .valid_o     (valid10_o),
`ifdef SOBEL_DIR_EN
        .dir_o       (dir10),
`endif
        .ready_i     (1'b1)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] mk(input int tl, t, tr, l, c, r, bl, b, br);
        return {8'(br), 8'(b), 8'(bl), 8'(r), 8'(c), 8'(l), 8'(tr), 8'(t), 8'(tl)};
    endfunction

    // Integer reference: straight from the Sobel definitions, independent of bit widths.
    function automatic void model(input logic [71:0] w, input logic te, input logic [7:0] th,
                                  output int pix, output int dir);
        int p[9];
        int gx, gy, ax, ay, m;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
        gx = p[2] - p[0] + 2 * (p[5] - p[3]) + p[8] - p[6];
        gy = p[0] - p[6] + 2 * (p[1] - p[7]) + p[2] - p[8];
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        m = (ax + ay > 255) ? 255 : ax + ay;
        pix = te ? ((m >= int'(th)) ? 255 : 0) : m;
        dir = (ax >= 2 * ay) ? 0 : (ay >= 2 * ax) ? 1 : ((gx < 0) == (gy < 0)) ? 2 : 3;
    endfunction

    // Called just after a rising edge; offers the window until it is accepted.
    task automatic send(input logic [71:0] w, input logic te, input logic [7:0] th,
                        input int ep, input int ed, input bit timed);
        int n = 0;
        win_i = w;
        thresh_en_i = te;
        thresh_i = th;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check(1'b0, "accept_timeout", 0, 1);
        else q.push_back('{ep, ed, cyc, timed});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && (q.size() > 0 || q10.size() > 0); n++) @(negedge clk);
        check(q.size() == 0 && q10.size() == 0, "drain_outstanding", q.size() + q10.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        occ <= reset_i ? 0 : occ + int'(valid_i && ready_o) - int'(valid_o && ready_i);

    // Monitor for the 8-bit instance: ready rule, stall stability, scoreboard pop.
    always @(negedge clk) begin
        m_rdy = !reset_i && !(occ == 3 && !ready_i);
        check(ready_o === m_rdy, "ready_o", ready_o, m_rdy);
        if (!reset_i && m_stalled) begin
            check(valid_o === 1'b1, "stall_valid_hold", valid_o, 1);
            check(pix_o === m_spix, "stall_pix_hold", pix_o, m_spix);
`ifdef SOBEL_DIR_EN
            check(dir_o === m_sdir, "stall_dir_hold", dir_o, m_sdir);
`endif
        end
        if (!reset_i && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (q.size() == 0) check(1'b0, "unexpected_output", pix_o, -1);
            else begin
                m_e = q.pop_front();
                check(pix_o == m_e.pix, "pix_o", pix_o, m_e.pix);
`ifdef SOBEL_DIR_EN
                check(dir_o == m_e.dir, "dir_o", dir_o, m_e.dir);
`endif
                if (m_e.timed) check(cyc - m_e.cyc == 3, "latency", cyc - m_e.cyc, 3);
            end
        end
        m_stalled = !reset_i && valid_o === 1'b1 && ready_i === 1'b0;
        m_spix = pix_o;
`ifdef SOBEL_DIR_EN
        m_sdir = dir_o;
`else
        m_sdir = 2'd0;
`endif
    end

    always @(negedge clk) begin
        if (!reset_i && valid10_o === 1'b1) begin
            if (q10.size() == 0) check(1'b0, "unexpected_output10", pix10, -1);
            else begin
                m_e10 = q10.pop_front();
                check(pix10 == m_e10.pix, "pix10", pix10, m_e10.pix);
`ifdef SOBEL_DIR_EN
                check(dir10 == m_e10.dir, "dir10", dir10, m_e10.dir);
`endif
                check(cyc - m_e10.cyc == 3, "latency10", cyc - m_e10.cyc, 3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        win_i = '0;
        thresh_en_i = 1'b0;
        thresh_i = '0;
        ready_i = 1'b1;
        valid10 = 1'b0;
        win10 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check(valid_o === 1'b0, "reset_valid_o", valid_o, 0);
        check(pix_o === 8'd0, "reset_pix_o", pix_o, 0);
        check(ready_o === 1'b1, "reset_ready_o", ready_o, 1);
`ifdef SOBEL_DIR_EN
        check(dir_o === 2'd0, "reset_dir_o", dir_o, 0);
`endif
        @(posedge clk);
        #1;
        // Directed windows, ready_i held high: expected values worked out by hand.
        send(mk(0, 128, 255, 0, 128, 255, 0, 128, 255), 1'b0, 8'd0, 255, 0, 1'b1);
        send(mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 1'b0, 8'd0, 0, 0, 1'b1);
        send(mk(0, 0, 10, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 20, 2, 1'b1);
        send(mk(0, 0, 10, 0, 0, 0, 0, 0, 0), 1'b1, 8'd20, 255, 2, 1'b1);
        send(mk(0, 0, 10, 0, 0, 0, 0, 0, 0), 1'b1, 8'd21, 0, 2, 1'b1);
        send(mk(255, 128, 0, 255, 128, 0, 255, 128, 0), 1'b0, 8'd0, 255, 0, 1'b1);
        send(mk(0, 0, 0, 0, 0, 30, 0, 0, 0), 1'b0, 8'd0, 60, 0, 1'b1);
        send(mk(0, 40, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 80, 1, 1'b1);
        send(mk(10, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 20, 3, 1'b1);
        send(mk(0, 0, 127, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 254, 2, 1'b1);
        send(mk(0, 0, 128, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 255, 2, 1'b1);
        send(mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 1'b1, 8'd0, 255, 0, 1'b1);
        wait_drain();
        // Eight distinct windows back-to-back against a 1,0,0,1 ready_i pattern.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < 9; k++) s_w[k*8 +: 8] = 8'((i * 37 + k * k * 13 + i * k * 29) % 256);
                    s_te = (i == 3 || i == 6);
                    s_th = 8'd90;
                    model(s_w, s_te, s_th, s_ep, s_ed);
                    send(s_w, s_te, s_th, s_ep, s_ed, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    ready_i = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
                ready_i = 1'b1;
            end
        join
        wait_drain();
        // Fill the pipe under backpressure, then reset mid-stall.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_w = mk(i * 20, 5, 200, 7, 9, 60 + i, 3, 1, 90);
            model(s_w, 1'b0, 8'd0, s_ep, s_ed);
            send(s_w, 1'b0, 8'd0, s_ep, s_ed, 1'b0);
        end
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        q.delete();
        ready_i = 1'b1;
        @(negedge clk);
        check(valid_o === 1'b0, "post_reset_valid_o", valid_o, 0);
        check(pix_o === 8'd0, "post_reset_pix_o", pix_o, 0);
        check(ready_o === 1'b1, "post_reset_ready_o", ready_o, 1);
        @(posedge clk);
        #1;
        send(mk(0, 0, 10, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 20, 2, 1'b1);
        wait_drain();
        // 10-bit instance: maximal step saturates 4092 down to 1023.
        for (int k = 0; k < 9; k++) win10[k*10 +: 10] = (k % 3 == 0) ? 10'd0 : (k % 3 == 2) ? 10'd1023 : 10'd512;
        valid10 = 1'b1;
        @(negedge clk);
        check(ready10 === 1'b1, "ready10", ready10, 1);
        q10.push_back('{1023, 0, cyc, 1'b1});
        @(posedge clk);
        #1;
        valid10 = 1'b0;
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_mask_pipe.md
Name: sobel_mask_pipe

Overview:
Parametrised, pipelined successor to the combinational Sobel pixel kernel. It takes one 3x3 window per transfer over a valid/ready handshake. It computes the horizontal and vertical Sobel gradients and outputs a saturated L1 magnitude or a binary edge decision, with three register stages. It sits between the line-buffer/window generator and the output pixel writer, and can be stalled by downstream backpressure.

Parameters:
PIXEL_W, 8, bits per input and output pixel (>= 2)
THRESH_MODE_DEF, 0, reset value of the internal mode flag (0 = magnitude, 1 = threshold)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
win_i  in  9*PIXEL_W  window, pixel k at [k*PIXEL_W +: PIXEL_W], k=0..8 row-major (0 top-left, 4 centre, 8 bottom-right)
valid_i  in  1  window valid
ready_o  out  1  block can accept a window this cycle
thresh_en_i  in  1  1 = threshold mode for this window (sampled with win_i)
thresh_i  in  PIXEL_W  threshold value (sampled with win_i)
pix_o  out  PIXEL_W  result pixel
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
dir_o  out  2  quantised gradient direction (present only with SOBEL_DIR_EN)

Behaviour:
- One clock: clk_i. Reset is synchronous and active-high on reset_i.
- Arithmetic, with G = PIXEL_W+3:
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6), signed G bits.
  - gy = (p0-p6) + 2(p1-p7) + (p2-p8), signed G bits.
  - All subtractions are zero-extended to G before operating; no truncation.
  - sum = |gx| + |gy|, unsigned G bits (max 8*(2^PIXEL_W-1) fits).
  - mag = all-ones if sum >= 2^PIXEL_W, else sum[PIXEL_W-1:0].
- Output value:
  - Magnitude mode (thresh_en = 0): pix_o = mag.
  - Threshold mode: pix_o = all-ones if mag >= thresh, else 0. Ties count as edge.
- Pipeline stages:
  - S1 registers gx, gy, thresh_en, thresh.
  - S2 registers sum and the carried fields.
  - S3 registers pix_o and valid_o.
  - Latency is exactly 3 cycles from an accepted input (valid_i & ready_o) to valid_o with no stall.
- Handshake:
  - Each stage has a valid bit.
  - Stage n loads when it is empty or when it is being drained in the same cycle.
  - S3 drains when valid_o & ready_i.
  - ready_o = ~s1_valid | s1_drains. Bubbles collapse.
  - Throughput is 1 window/cycle with ready_i held high.
- Stall rules:
  - When valid_o=1 and ready_i=0, pix_o, valid_o and dir_o are held stable.
  - Upstream stages fill and then hold; no data is lost or duplicated.
- Simultaneous accept and drain on a full pipe keeps it full. Data order is strictly FIFO.
- Reset (any cycle, including mid-stall):
  - All stage valid bits, valid_o, pix_o and dir_o go to 0.
  - ready_o is 0 during the reset cycle and 1 on the first cycle after it.
  - In-flight windows are discarded.
- Inputs are sampled only on accept. thresh_i changes do not affect windows already in flight.
- THRESH_MODE_DEF is used as the thresh_en value in the single case where valid_i is low and the register must hold a defined value after reset.

Optional Feature:
- Macro SOBEL_DIR_EN.
- When defined:
  - S2 computes dir from gx/gy and carries it to S3; dir_o is driven.
  - dir = 0 if |gx| >= 2|gy| (vertical edge).
  - Else dir = 1 if |gy| >= 2|gx| (horizontal edge).
  - Else dir = 2 if sign(gx) == sign(gy) (45 deg).
  - Else dir = 3 (135 deg). Zero counts as non-negative.
  - Reset value is 0; dir_o holds with pix_o under stall.
- When undefined: the dir_o port and its logic are absent; everything else is identical.

Decomposition:
- Package sobel_pkg holds:
  - localparam function grad_width(PIXEL_W) returning PIXEL_W+3.
  - typedef sobel_dir_e (DIR_VERT, DIR_HORIZ, DIR_DIAG45, DIR_DIAG135).
  - The window index constants P_TL..P_BR.
- One sub-module, sobel_abs_sat: combinational |gx|+|gy| with saturation to PIXEL_W. It is instantiated in S2/S3 and reusable by the later L2 variant.

Test Plan:
- PIXEL_W=8, left column 0 and right column 255, centre 128, magnitude mode → gx=1020, gy=0, pix_o=255 exactly 3 cycles after accept.
- Flat window, all pixels 100 → pix_o=0; with SOBEL_DIR_EN, dir_o=0.
- p2=10, all others 0 → gx=10, gy=10, pix_o=20. Same window with thresh_en=1, thresh=20 → 255; with thresh=21 → 0. With SOBEL_DIR_EN, dir_o=2.
- Stream of 8 distinct windows back-to-back with ready_i toggling 1,0,0,1,… → all 8 results in order, none dropped or duplicated, outputs stable while stalled, ready_o=0 only when the pipe is full and stalled.
- Fill the pipe with 3 windows, hold ready_i=0, assert reset_i for 1 cycle → valid_o=0 and pix_o=0 the next cycle, ready_o=1 after reset, and the next accepted window appears after 3 cycles.
- PIXEL_W=10, max step window (0 vs 1023) → sum 4092 saturates to pix_o=1023.
